conv3x3_window_gen: RTL and testbench

//  Producer side of the 3x3 convolution window interface: turns a raster-order pixel stream
//  (one WI-bit pixel per valid cycle, row-major) into 3x3 windows on three row buses.

---
 rtl/conv3x3_window_gen_if.sv | 40 ++++
 rtl/conv3x3_window_gen.sv | 97 +++++++++
 tb/tb_conv3x3_window_gen.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/conv3x3_window_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : conv3x3_window_gen_if
//  Purpose  : Pixel-stream in / 3x3-window out bundle of the window generator.
//  Revision : 1.0  initial release
// ============================================================================
interface conv3x3_window_gen_if #(
    parameter int WI = 8
);
    logic              iInValid;
    logic [WI-1:0]     iInData;
    logic              oOutValid;
    logic [3*WI-1:0]   oWindowOutRow1;
    logic [3*WI-1:0]   oWindowOutRow2;
    logic [3*WI-1:0]   oWindowOutRow3;
    logic              oFrameDone;

    // Upstream pixel source
    modport master (
        output iInValid,
        output iInData,
        input  oOutValid,
        input  oWindowOutRow1,
        input  oWindowOutRow2,
        input  oWindowOutRow3,
        input  oFrameDone
    );

    // Window generator
    modport slave (
        input  iInValid,
        input  iInData,
        output oOutValid,
        output oWindowOutRow1,
        output oWindowOutRow2,
        output oWindowOutRow3,
        output oFrameDone
    );
endinterface
`default_nettype wire

// File: rtl/conv3x3_window_gen.sv
`default_nettype none
// ============================================================================
//  Module   : conv3x3_window_gen
//  Purpose  : Raster pixel stream to 3x3 sliding windows (valid padding).
//  Revision : 1.0  initial release
// ============================================================================
module conv3x3_window_gen #(
    parameter int WI    = 8,
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
) (
    input  wire logic               iClk,
    input  wire logic               iRst,
    conv3x3_window_gen_if.slave     win_if
);

    localparam int c_CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int c_RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [c_CW-1:0] c_LAST_COL      = c_CW'(IMG_W - 1);
    localparam logic [c_RW-1:0] c_LAST_ROW      = c_RW'(IMG_H - 1);
    localparam logic [c_CW-1:0] c_FIRST_WIN_COL = c_CW'(2);
    localparam logic [c_RW-1:0] c_FIRST_WIN_ROW = c_RW'(2);

    logic [c_CW-1:0]   r_col;
    logic [c_RW-1:0]   r_row;
    logic [WI-1:0]     r_lb0 [IMG_W];
    logic [WI-1:0]     r_lb1 [IMG_W];
    logic [3*WI-1:0]   r_win1;
    logic [3*WI-1:0]   r_win2;
    logic [3*WI-1:0]   r_win3;
    logic              r_valid;
    logic              r_done;

    logic              w_accept;
    logic [WI-1:0]     w_top;
    logic [WI-1:0]     w_mid;
    logic              w_last_col;
    logic              w_last_row;
    logic              w_win_ok;

    assign w_accept   = win_if.iInValid;
    assign w_top      = r_lb1[r_col];
    assign w_mid      = r_lb0[r_col];
    assign w_last_col = (r_col == c_LAST_COL);
    assign w_last_row = (r_row == c_LAST_ROW);
    // Column gate keeps windows from wrapping across a row boundary.
    assign w_win_ok   = (r_row >= c_FIRST_WIN_ROW) && (r_col >= c_FIRST_WIN_COL);

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_last_col) begin
                r_col <= '0;
                r_row <= w_last_row ? '0 : r_row + c_RW'(1);
            end else begin
                r_col <= r_col + c_CW'(1);
            end
        end
    end

    // Storage is deliberately left unreset; stale rows only feed windows that are never flagged.
    always_ff @(posedge iClk) begin
        if (w_accept && !iRst) begin
            r_lb1[r_col] <= w_mid;
            r_lb0[r_col] <= win_if.iInData;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_win1  <= '0;
            r_win2  <= '0;
            r_win3  <= '0;
        end else begin
            r_valid <= w_accept && w_win_ok;
            r_done  <= w_accept && w_last_col && w_last_row;
            if (w_accept) begin
                r_win1 <= {r_win1[2*WI-1:0], w_top};
                r_win2 <= {r_win2[2*WI-1:0], w_mid};
                r_win3 <= {r_win3[2*WI-1:0], win_if.iInData};
            end
        end
    end

    assign win_if.oOutValid      = r_valid;
    assign win_if.oFrameDone     = r_done;
    assign win_if.oWindowOutRow1 = r_win1;
    assign win_if.oWindowOutRow2 = r_win2;
    assign win_if.oWindowOutRow3 = r_win3;

endmodule
`default_nettype wire

// File: tb/tb_conv3x3_window_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_conv3x3_window_gen
//  Purpose  : Self-checking bench for conv3x3_window_gen on a 4x4 image.
//  Revision : 1.0  initial release
// ============================================================================
module tb_conv3x3_window_gen;

    localparam int WI    = 8;
    localparam int IMG_W = 4;
    localparam int IMG_H = 4;

    typedef struct {
        logic [WI-1:0]   pix;
        logic            exp_valid;
        logic [3*WI-1:0] e1;
        logic [3*WI-1:0] e2;
        logic [3*WI-1:0] e3;
        logic            exp_done;
    } vec_t;

    typedef struct {
        logic [3*WI-1:0] r1;
        logic [3*WI-1:0] r2;
        logic [3*WI-1:0] r3;
        logic            done;
    } win_t;

    logic clk;
    logic rst;
    conv3x3_window_gen_if #(.WI(WI)) bus ();

    conv3x3_window_gen #(.WI(WI), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .iClk   (clk),
        .iRst   (rst),
        .win_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   n_win  = 0;
    int   n_done = 0;
    win_t sb_q[$];

    logic [WI-1:0] img [IMG_H][IMG_W];
    int   m_row = 0;
    int   m_col = 0;
    logic sampled_v   = 1'b0;
    logic sampled_rst = 1'b0;

    vec_t tbl [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: full 2D image of the current frame; windows are read straight out of it.
    task automatic send(input logic [WI-1:0] pix);
        win_t w;
        bus.iInValid = 1'b1;
        bus.iInData  = pix;
        img[m_row][m_col] = pix;
        if (m_row >= 2 && m_col >= 2) begin
            w.r1 = {img[m_row-2][m_col-2], img[m_row-2][m_col-1], img[m_row-2][m_col]};
            w.r2 = {img[m_row-1][m_col-2], img[m_row-1][m_col-1], img[m_row-1][m_col]};
            w.r3 = {img[m_row][m_col-2],   img[m_row][m_col-1],   img[m_row][m_col]};
            w.done = (m_row == IMG_H-1) && (m_col == IMG_W-1);
            sb_q.push_back(w);
        end
        m_col++;
        if (m_col == IMG_W) begin
            m_col = 0;
            m_row = (m_row == IMG_H-1) ? 0 : m_row + 1;
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        bus.iInValid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic with_valid);
        chk("sb_empty_before_reset", 32'(sb_q.size()), 32'd0);
        rst = 1'b1;
        bus.iInValid = with_valid;
        bus.iInData  = 8'h5A;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.iInValid = 1'b0;
        m_row = 0;
        m_col = 0;
        chk("reset_valid", 32'(bus.oOutValid), 32'd0);
        chk("reset_done",  32'(bus.oFrameDone), 32'd0);
        chk("reset_row1",  32'(bus.oWindowOutRow1), 32'd0);
        chk("reset_row2",  32'(bus.oWindowOutRow2), 32'd0);
        chk("reset_row3",  32'(bus.oWindowOutRow3), 32'd0);
    endtask

    task automatic run_table();
        for (int i = 0; i < 16; i++) begin
            send(tbl[i].pix);
            chk($sformatf("tbl_valid[%0d]", i), 32'(bus.oOutValid), 32'(tbl[i].exp_valid));
            chk($sformatf("tbl_done[%0d]", i),  32'(bus.oFrameDone), 32'(tbl[i].exp_done));
            if (tbl[i].exp_valid) begin
                chk($sformatf("tbl_row1[%0d]", i), 32'(bus.oWindowOutRow1), 32'(tbl[i].e1));
                chk($sformatf("tbl_row2[%0d]", i), 32'(bus.oWindowOutRow2), 32'(tbl[i].e2));
                chk($sformatf("tbl_row3[%0d]", i), 32'(bus.oWindowOutRow3), 32'(tbl[i].e3));
            end
        end
        bus.iInValid = 1'b0;
    endtask

    task automatic count_check(input string name, input int exp_win, input int exp_done);
        idle(2);
        chk({name, "_windows"}, 32'(n_win), 32'(exp_win));
        chk({name, "_frame_done"}, 32'(n_done), 32'(exp_done));
        n_win  = 0;
        n_done = 0;
    endtask

    always @(posedge clk) begin
        sampled_v   <= bus.iInValid;
        sampled_rst <= rst;
    end

    always @(negedge clk) begin
        win_t w;
        if (sampled_rst) begin
            chk("mon_valid_in_reset", 32'(bus.oOutValid), 32'd0);
        end else begin
            if (bus.oOutValid && !sampled_v)
                chk("mon_valid_after_idle", 32'(bus.oOutValid), 32'd0);
            if (bus.oFrameDone && !bus.oOutValid)
                chk("mon_done_without_valid", 32'(bus.oOutValid), 32'd1);
            if (bus.oOutValid) begin
                n_win++;
                if (bus.oFrameDone) n_done++;
                if (sb_q.size() == 0) begin
                    chk("mon_unexpected_window", 32'(bus.oOutValid), 32'd0);
                end else begin
                    w = sb_q.pop_front();
                    chk("sb_row1", 32'(bus.oWindowOutRow1), 32'(w.r1));
                    chk("sb_row2", 32'(bus.oWindowOutRow2), 32'(w.r2));
                    chk("sb_row3", 32'(bus.oWindowOutRow3), 32'(w.r3));
                    chk("sb_done", 32'(bus.oFrameDone), 32'(w.done));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            tbl[i].pix       = 8'(i);
            tbl[i].exp_valid = 1'b0;
            tbl[i].e1        = '0;
            tbl[i].e2        = '0;
            tbl[i].e3        = '0;
            tbl[i].exp_done  = 1'b0;
        end
        tbl[10] = '{8'd10, 1'b1, 24'h000102, 24'h040506, 24'h08090a, 1'b0};
        tbl[11] = '{8'd11, 1'b1, 24'h010203, 24'h050607, 24'h090a0b, 1'b0};
        tbl[14] = '{8'd14, 1'b1, 24'h040506, 24'h08090a, 24'h0c0d0e, 1'b0};
        tbl[15] = '{8'd15, 1'b1, 24'h050607, 24'h090a0b, 24'h0d0e0f, 1'b1};

        rst = 1'b1;
        bus.iInValid = 1'b0;
        bus.iInData  = '0;
        repeat (3) @(posedge clk);
        #1;
        do_reset(1'b0);

        // Back-to-back frame
        run_table();
        count_check("s1", 4, 1);

        // Same frame with random idle gaps
        for (int i = 0; i < 16; i++) begin
            send(8'(i));
            if (i != 15) idle($urandom_range(1, 3));
        end
        idle(1);
        count_check("s2", 4, 1);

        // Two frames back-to-back, second offset by 100
        for (int i = 0; i < 16; i++) send(8'(i));
        for (int i = 0; i < 16; i++) begin
            send(8'(100 + i));
            if (i == 10) begin
                chk("f2_first_row1", 32'(bus.oWindowOutRow1), 32'h646566);
                chk("f2_first_row2", 32'(bus.oWindowOutRow2), 32'h68696a);
                chk("f2_first_row3", 32'(bus.oWindowOutRow3), 32'h6c6d6e);
            end
        end
        bus.iInValid = 1'b0;
        count_check("s3", 8, 2);

        // Reset after pixel 9 discards the partial frame
        for (int i = 0; i < 10; i++) send(8'(i));
        bus.iInValid = 1'b0;
        do_reset(1'b0);
        for (int i = 0; i < 16; i++) send(8'(i));
        bus.iInValid = 1'b0;
        count_check("s4", 4, 1);

        // Sign-bit heavy pixels pass through unchanged
        for (int i = 0; i < 16; i++) begin
            send((((i / IMG_W) + (i % IMG_W)) % 2 == 1) ? 8'hFF : 8'h80);
            if (i == 10) begin
                chk("alt_row1", 32'(bus.oWindowOutRow1), 32'h80FF80);
                chk("alt_row2", 32'(bus.oWindowOutRow2), 32'hFF80FF);
                chk("alt_row3", 32'(bus.oWindowOutRow3), 32'h80FF80);
            end
        end
        bus.iInValid = 1'b0;
        count_check("s5", 4, 1);

        // Reset with a pixel presented: pixel dropped, next frame starts at (0,0)
        for (int i = 0; i < 5; i++) send(8'(i + 50));
        bus.iInValid = 1'b0;
        do_reset(1'b1);
        run_table();
        count_check("s6", 4, 1);

        chk("sb_empty_at_end", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
